// File: rtl/keccak_msg_feeder_if.sv
// Signal bundle between the message feeder, its byte source, the keccak core and the command layer.
// master is the feeder's own view; slave is the view of everything around it.
interface keccak_msg_feeder_if;
  logic         start;
  logic         empty_msg;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         core_reset;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [511:0] out;
  logic         out_ready;
  logic [511:0] digest;
  logic         digest_valid;
  logic         busy;
  logic [31:0]  msg_len;

  modport master (
    input  start, empty_msg, s_data, s_valid, s_last, buffer_full, out, out_ready,
    output s_ready, core_reset, in, in_ready, is_last, byte_num,
           digest, digest_valid, busy, msg_len
  );

  modport slave (
    output start, empty_msg, s_data, s_valid, s_last, buffer_full, out, out_ready,
    input  s_ready, core_reset, in, in_ready, is_last, byte_num,
           digest, digest_valid, busy, msg_len
  );
endinterface

// File: rtl/keccak_msg_feeder.sv
// Packs a byte stream big-endian into 32-bit words for the keccak core, appends the
// terminal partial/empty word, clears the core before each message and captures the digest.
module keccak_msg_feeder #(
  parameter int unsigned CLR_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  keccak_msg_feeder_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_PACK, S_SEND, S_WAIT} state_e;

  localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  clr_cnt_q, clr_cnt_d;
  logic           empty_q, empty_d;
  logic           extra_q, extra_d;   // full final word still owes a trailing empty word
  logic [1:0]     pos_q, pos_d;
  logic [31:0]    word_q, word_d;
  logic           is_last_q, is_last_d;
  logic [1:0]     byte_num_q, byte_num_d;
  logic [31:0]    msg_len_q, msg_len_d;
  logic [511:0]   digest_q, digest_d;
  logic           digest_valid_q, digest_valid_d;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    empty_d        = empty_q;
    extra_d        = extra_q;
    pos_d          = pos_q;
    word_d         = word_q;
    is_last_d      = is_last_q;
    byte_num_d     = byte_num_q;
    msg_len_d      = msg_len_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d        = S_CLR;
          empty_d        = bus.empty_msg;
          msg_len_d      = '0;
          digest_valid_d = 1'b0;
          clr_cnt_d      = '0;
        end
      end
      S_CLR: begin
        if (clr_cnt_q == CLR_LAST) begin
          word_d     = '0;
          pos_d      = '0;
          byte_num_d = '0;
          extra_d    = 1'b0;
          is_last_d  = empty_q;
          state_d    = empty_q ? S_SEND : S_PACK;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      S_PACK: begin
        if (bus.s_valid) begin
          word_d    = word_q | ({bus.s_data, 24'h0} >> {pos_q, 3'b000});
          pos_d     = pos_q + 2'd1;
          msg_len_d = msg_len_q + 32'd1;
          if (bus.s_last || pos_q == 2'd3) begin
            state_d    = S_SEND;
            is_last_d  = bus.s_last && (pos_q != 2'd3);
            byte_num_d = (bus.s_last && pos_q != 2'd3) ? pos_q + 2'd1 : 2'd0;
            extra_d    = bus.s_last && (pos_q == 2'd3);
          end
        end
      end
      S_SEND: begin
        if (!bus.buffer_full) begin
          word_d     = '0;
          byte_num_d = '0;
          if (is_last_q) begin
            state_d   = S_WAIT;
            is_last_d = 1'b0;
          end else if (extra_q) begin
            extra_d   = 1'b0;
            is_last_d = 1'b1;
          end else begin
            state_d = S_PACK;
            pos_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (bus.out_ready) begin
          digest_d       = bus.out;
          digest_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      clr_cnt_q      <= '0;
      empty_q        <= 1'b0;
      extra_q        <= 1'b0;
      pos_q          <= '0;
      word_q         <= '0;
      is_last_q      <= 1'b0;
      byte_num_q     <= '0;
      msg_len_q      <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      empty_q        <= empty_d;
      extra_q        <= extra_d;
      pos_q          <= pos_d;
      word_q         <= word_d;
      is_last_q      <= is_last_d;
      byte_num_q     <= byte_num_d;
      msg_len_q      <= msg_len_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  // The core is held in reset for as long as this block is.
  assign bus.core_reset   = (state_q == S_CLR) || !reset;
  assign bus.s_ready      = (state_q == S_PACK);
  assign bus.in_ready     = (state_q == S_SEND);
  assign bus.in           = word_q;
  assign bus.is_last      = is_last_q;
  assign bus.byte_num     = byte_num_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.msg_len      = msg_len_q;

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
- Source side of the keccak core's 32-bit message-input protocol (in / in_ready / is_last / byte_num / buffer_full).
- Accepts a byte stream per message and packs it big-endian into 32-bit words; the first byte goes in bits [31:24].
- Drives the core, inserts the terminal partial or empty word, and clears the core before each message.
- Waits for out_ready and captures the 512-bit digest. Sits between the hash command layer and keccak.

Parameters:
- CLR_CYCLES, 1, number of cycles core_reset is held high at the start of each message (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  begin a new message; honoured only in IDLE
- empty_msg  input  1  sampled with start; 1 means zero-length message (no bytes follow)
- s_data  input  8  message byte
- s_valid  input  1  byte valid
- s_last  input  1  qualifies the final byte of the message
- s_ready  output  1  byte accepted on edge where s_valid & s_ready
- core_reset  output  1  active-high reset to keccak
- in  output  32  word to keccak
- in_ready  output  1  word valid to keccak
- is_last  output  1  final-word flag to keccak
- byte_num  output  2  valid bytes in final word (0..3)
- buffer_full  input  1  keccak backpressure
- out  input  512  keccak digest
- out_ready  input  1  keccak digest valid
- digest  output  512  captured digest
- digest_valid  output  1  high from capture until next accepted start
- busy  output  1  high in every state except IDLE
- msg_len  output  32  bytes accepted for the current or most recent message

Behaviour:
- Reset (reset==0 at posedge) has priority over everything, including mid-message.
  - Forces IDLE, clears the pack register and byte position.
  - Outputs after reset: s_ready=0, in=0, in_ready=0, is_last=0, byte_num=0, digest=0, digest_valid=0, busy=0, msg_len=0.
  - core_reset=1 while reset is low, then 0 in IDLE.
- States: IDLE, CLR, PACK, SEND, WAIT.
- IDLE → CLR on start.
  - Latch empty_msg, clear msg_len, clear digest_valid.
- CLR: core_reset=1 for exactly CLR_CYCLES cycles.
  - Then go to SEND if empty_msg was latched, with word=0, is_last=1, byte_num=0.
  - Otherwise go to PACK with position=0.
- PACK: s_ready=1.
  - Each accepted byte is written to bits [31-8*pos -: 8]; pos increments and msg_len increments.
  - Unfilled bytes are 0.
  - 4th byte with s_last=0: go to SEND, full word, is_last=0; return to PACK afterwards.
  - s_last at pos p<3: go to SEND, is_last=1, byte_num=p+1.
  - s_last at pos 3 (word full): go to SEND with the full word and is_last=0, then a second SEND with word=0, is_last=1, byte_num=0.
  - s_ready is 0 outside PACK, so there is at most one word in flight and no overlap.
- SEND: in_ready=1; in, is_last and byte_num are registered and stable.
  - The word is accepted on a posedge with buffer_full==0.
  - While buffer_full==1, hold all outputs unchanged, for any number of cycles.
  - After acceptance: in_ready=0 and is_last=0 on the next cycle.
  - Next state: PACK, the pending extra SEND, or WAIT (after the is_last word).
  - byte_num is don't-care when is_last=0; drive 0.
- WAIT: on out_ready==1, digest←out, digest_valid←1, go to IDLE.
  - start in WAIT is ignored.
- start while busy is ignored. s_last or s_valid in non-PACK states is ignored (not consumed).
- msg_len wraps mod 2^32.

Test Plan:
- "The quick brown fox jumps over the lazy dog" (43 bytes), buffer_full=0.
  - Expect 10 full words then "dog"<<8 with is_last=1, byte_num=3.
  - digest=01dedd5de4ef…4bf0d450, msg_len=43.
- Same text plus "." (44 bytes).
  - Expect 11 full words, then word 0 with is_last=1, byte_num=0.
  - digest=18f4f4bd4196…ba6460f8.
- start with empty_msg=1.
  - Expect core_reset for CLR_CYCLES, then a single word 0 with is_last=1, byte_num=0.
  - digest=a69f73cca23a…281dcd26, msg_len=0.
- Bytes A1 A2 A3 A4 A5.
  - Expect words A1A2A3A4 (is_last=0), then A5000000 (is_last=1, byte_num=1).
  - digest=edc8d5dd93da…eee6af43f9.
- Force buffer_full=1 for 5 cycles during the 2nd SEND.
  - Expect in, in_ready, is_last stable throughout and s_ready=0.
  - Digest unchanged versus the unstalled run.
- Assert reset low mid-PACK after 6 bytes.
  - Expect all outputs at reset values next cycle.
  - A fresh 5-byte message afterwards yields the edc8…43f9 digest.
